// File: rtl/highscore_table_pkg.sv
// Shared types and constants for the highscore table: packed time width and FSM states.
package highscore_table_pkg;

   localparam int TIME_W      = 15;
   localparam int ENTRIES_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_INSERT = 2'd2,
      ST_DONE   = 2'd3
   } hs_state_t;

   function automatic logic [TIME_W-1:0] pack_time(input logic [6:0] seconds,
                                                   input logic [7:0] hundredths);
      return {seconds, hundredths};
   endfunction

endpackage

// File: rtl/highscore_cmp.sv
// Combinational less-than of a candidate time against one slot; an empty slot always loses.
module highscore_cmp
   import highscore_table_pkg::*;
(
   input  logic [TIME_W-1:0] cand_i,
   input  logic [TIME_W-1:0] slot_i,
   input  logic              slot_valid_i,
   output logic              less_o
);

   // BCD digit order makes the plain unsigned compare correct.
   assign less_o = (!slot_valid_i) || (cand_i < slot_i);

endmodule

// File: rtl/highscore_table.sv
// Sorted table of the best completion times, filled by a scan/shift FSM.
// Optional HIGHSCORE_CLEAR_EN adds a clear_req input that empties the table from IDLE.
module highscore_table
   import highscore_table_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      insert_req,
   input  logic [6:0]                ins_seconds,
   input  logic [7:0]                ins_hundredths,
`ifdef HIGHSCORE_CLEAR_EN
   input  logic                      clear_req,
`endif
   output logic                      busy,
   output logic                      rank_vld,
   output logic [2:0]                rank,
   output logic [ENTRIES-1:0]        hs_valid,
   output logic [ENTRIES*TIME_W-1:0] hs_time
);

   hs_state_t         state_q;
   logic [2:0]        idx_q;
   logic [2:0]        pos_q;
   logic [TIME_W-1:0] cand_q;
   logic [TIME_W-1:0] slot_q [ENTRIES];
   logic [ENTRIES-1:0] vld_q;
   logic              busy_q;
   logic              rank_vld_q;
   logic [2:0]        rank_q;

   logic [TIME_W-1:0] cur_slot_s;
   logic              cur_vld_s;
   logic              hit_s;

   // Select the slot currently being scanned; idx never exceeds ENTRIES-1 in SCAN.
   always_comb begin
      cur_slot_s = '0;
      cur_vld_s  = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (idx_q == 3'(i)) begin
            cur_slot_s = slot_q[i];
            cur_vld_s  = vld_q[i];
         end
      end
   end

   highscore_cmp u_cmp (
      .cand_i       (cand_q),
      .slot_i       (cur_slot_s),
      .slot_valid_i (cur_vld_s),
      .less_o       (hit_s)
   );

   // Control FSM, shift array and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         pos_q      <= 3'd0;
         cand_q     <= '0;
         vld_q      <= '0;
         busy_q     <= 1'b0;
         rank_vld_q <= 1'b0;
         rank_q     <= 3'd0;
         for (int i = 0; i < ENTRIES; i++) slot_q[i] <= '0;
      end else begin
         rank_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
`ifdef HIGHSCORE_CLEAR_EN
               if (clear_req) begin
                  vld_q <= '0;
                  for (int i = 0; i < ENTRIES; i++) slot_q[i] <= '0;
               end else
`endif
               if (insert_req) begin
                  cand_q  <= pack_time(ins_seconds, ins_hundredths);
                  idx_q   <= 3'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (hit_s) begin
                  pos_q   <= idx_q;
                  state_q <= ST_INSERT;
               end else if (idx_q == 3'(ENTRIES - 1)) begin
                  // Unplaced times take a no-op INSERT so the latency stays ENTRIES+2.
                  pos_q   <= 3'(ENTRIES);
                  state_q <= ST_INSERT;
               end else begin
                  idx_q <= idx_q + 3'd1;
               end
            end
            ST_INSERT: begin
               for (int i = 1; i < ENTRIES; i++) begin
                  if (3'(i) > pos_q) begin
                     slot_q[i] <= slot_q[i-1];
                     vld_q[i]  <= vld_q[i-1];
                  end else if (3'(i) == pos_q) begin
                     slot_q[i] <= cand_q;
                     vld_q[i]  <= 1'b1;
                  end
               end
               if (pos_q == 3'd0) begin
                  slot_q[0] <= cand_q;
                  vld_q[0]  <= 1'b1;
               end
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               rank_vld_q <= 1'b1;
               rank_q     <= pos_q;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Flatten the slot registers onto the output bus.
   always_comb begin
      hs_time = '0;
      for (int i = 0; i < ENTRIES; i++) hs_time[i*TIME_W +: TIME_W] = slot_q[i];
   end

   assign busy     = busy_q;
   assign rank_vld = rank_vld_q;
   assign rank     = rank_q;
   assign hs_valid = vld_q;

endmodule

// File: tb/tb_highscore_table.sv
// Directed self-checking bench for highscore_table (ENTRIES=3, TIME_W=15).
module tb_highscore_table;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        insert_req;
   logic [6:0]  ins_seconds;
   logic [7:0]  ins_hundredths;
`ifdef HIGHSCORE_CLEAR_EN
   logic        clear_req;
`endif
   logic        busy;
   logic        rank_vld;
   logic [2:0]  rank;
   logic [2:0]  hs_valid;
   logic [44:0] hs_time;

   int total_cnt = 0;
   int pass_cnt  = 0;

   highscore_table #(.ENTRIES(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .insert_req     (insert_req),
      .ins_seconds    (ins_seconds),
      .ins_hundredths (ins_hundredths),
`ifdef HIGHSCORE_CLEAR_EN
      .clear_req      (clear_req),
`endif
      .busy           (busy),
      .rank_vld       (rank_vld),
      .rank           (rank),
      .hs_valid       (hs_valid),
      .hs_time        (hs_time)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] t(input logic [6:0] s, input logic [7:0] h);
      return {s, h};
   endfunction

   function automatic logic [44:0] tbl(input logic [14:0] s0, input logic [14:0] s1,
                                      input logic [14:0] s2);
      return {s2, s1, s0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Issue one insert and watch 12 cycles for exactly one rank_vld at the given latency.
   task automatic do_insert(input string tag, input logic [6:0] s, input logic [7:0] h,
                            input logic [2:0] exp_rank, input int exp_lat);
      int pulses;
      int lat;
      pulses = 0;
      lat    = -1;
      ins_seconds    = s;
      ins_hundredths = h;
      insert_req     = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (rank_vld) begin
            pulses++;
            if (lat < 0) lat = k;
         end
      end
      check({tag, " pulses"}, 64'(pulses), 64'd1);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " rank"}, 64'(rank), 64'(exp_rank));
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0;
      insert_req = 1'b0;
      ins_seconds = 7'h00;
      ins_hundredths = 8'h00;
`ifdef HIGHSCORE_CLEAR_EN
      clear_req = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset rank_vld", 64'(rank_vld), 64'd0);
      check("reset rank", 64'(rank), 64'd0);
      check("reset hs_valid", 64'(hs_valid), 64'd0);
      check("reset hs_time", 64'(hs_time), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First insert into an empty table
      do_insert("ins 12.34", 7'h12, 8'h34, 3'd0, 3);
      check("t1 valid", 64'(hs_valid), 64'h1);
      check("t1 slot0", 64'(hs_time[14:0]), 64'(t(7'h12, 8'h34)));

      // New best, then a worst that lands in the last free slot
      do_insert("ins 05.50", 7'h05, 8'h50, 3'd0, 3);
      do_insert("ins 30.00", 7'h30, 8'h00, 3'd2, 5);
      check("t2 valid", 64'(hs_valid), 64'h7);
      check("t2 table", 64'(hs_time), 64'(tbl(t(7'h05,8'h50), t(7'h12,8'h34), t(7'h30,8'h00))));

      // Full table: too slow is not placed, a middle time evicts the last entry
      do_insert("ins 45.00", 7'h45, 8'h00, 3'd3, 5);
      check("t3 unchanged", 64'(hs_time), 64'(tbl(t(7'h05,8'h50), t(7'h12,8'h34), t(7'h30,8'h00))));
      do_insert("ins 10.00", 7'h10, 8'h00, 3'd1, 4);
      check("t3 evict", 64'(hs_time), 64'(tbl(t(7'h05,8'h50), t(7'h10,8'h00), t(7'h12,8'h34))));
      check("t3 valid", 64'(hs_valid), 64'h7);

      // Tie with slot 0 goes behind it
      do_insert("ins tie 05.50", 7'h05, 8'h50, 3'd1, 4);
      check("t4 table", 64'(hs_time), 64'(tbl(t(7'h05,8'h50), t(7'h05,8'h50), t(7'h10,8'h00))));

      // Requests while busy and on the DONE cycle are dropped
      ins_seconds = 7'h40; ins_hundredths = 8'h00; insert_req = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0;
      @(posedge clk); #1;
      check("t5 busy scan", 64'(busy), 64'd1);
      ins_seconds = 7'h00; ins_hundredths = 8'h01; insert_req = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5 busy done", 64'(busy), 64'd1);
      check("t5 no early vld", 64'(rank_vld), 64'd0);
      insert_req = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0;
      check("t5 vld", 64'(rank_vld), 64'd1);
      check("t5 rank", 64'(rank), 64'd3);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (rank_vld) pulses++;
      end
      check("t5 extra pulses", 64'(pulses), 64'd0);
      check("t5 busy idle", 64'(busy), 64'd0);
      check("t5 table", 64'(hs_time), 64'(tbl(t(7'h05,8'h50), t(7'h05,8'h50), t(7'h10,8'h00))));

      // Reset in the middle of SCAN
      ins_seconds = 7'h01; ins_hundredths = 8'h00; insert_req = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst busy", 64'(busy), 64'd0);
      check("rst rank_vld", 64'(rank_vld), 64'd0);
      check("rst rank", 64'(rank), 64'd0);
      check("rst hs_valid", 64'(hs_valid), 64'd0);
      check("rst hs_time", 64'(hs_time), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_insert("ins 20.00", 7'h20, 8'h00, 3'd0, 3);
      check("post rst table", 64'(hs_time), 64'(tbl(t(7'h20,8'h00), 15'd0, 15'd0)));

`ifdef HIGHSCORE_CLEAR_EN
      // Clear beats a simultaneous insert
      ins_seconds = 7'h01; ins_hundredths = 8'h00;
      insert_req = 1'b1; clear_req = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0; clear_req = 1'b0;
      check("clr valid", 64'(hs_valid), 64'd0);
      check("clr time", 64'(hs_time), 64'd0);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (rank_vld) pulses++;
      end
      check("clr no vld", 64'(pulses), 64'd0);
      do_insert("ins 12.34 b", 7'h12, 8'h34, 3'd0, 3);
      // Clear while busy is ignored
      ins_seconds = 7'h50; ins_hundredths = 8'h00; insert_req = 1'b1;
      @(posedge clk); #1;
      insert_req = 1'b0; clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("clr busy valid", 64'(hs_valid), 64'h3);
      check("clr busy table", 64'(hs_time), 64'(tbl(t(7'h12,8'h34), t(7'h50,8'h00), 15'd0)));
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
